tape_rmw_memory: RTL
====================

TAPE_RMW_MEMORY -- requirements
Module: tape_rmw_memory

Interface
REQ-001 SHALL have parameter CELL_W, default 8, data cell width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of cells, power of 2, at least 2; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = modulo-2^CELL_W arithmetic, 1 = unsigned saturating arithmetic.
REQ-004 SHALL have port clk_i, input, 1, single system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clr_i, input, 1, request to clear the whole tape.
REQ-007 SHALL have port busy_o, output, 1, high while a clear is in progress.
REQ-008 SHALL have ports ren_i (1), raddr_i (AW), rdata_o (CELL_W, output), rvalid_o (1, output): read port.
REQ-009 SHALL have ports wen_i (1), waddr_i (AW), wdata_i (CELL_W): plain write port.
REQ-010 SHALL have ports op_valid_i (1), op_ready_o (1, output), op_addr_i (AW), op_delta_i (CELL_W, two's-complement): read-modify-write request.
REQ-011 SHALL have ports op_done_o (1, output) and op_result_o (CELL_W, output): RMW completion pulse and the value written.

Function
REQ-012 SHALL implement FSM states CLEAR, IDLE, RMW_RD and RMW_WR.
REQ-013 CLEAR SHALL write zero to one cell per cycle, address 0 to DEPTH-1; after writing cell DEPTH-1 it SHALL go to IDLE, so a clear lasts exactly DEPTH cycles.
REQ-014 busy_o SHALL be high exactly in CLEAR; ren_i, wen_i and op_valid_i SHALL be ignored in CLEAR.
REQ-015 In IDLE, clr_i SHALL enter CLEAR next cycle, with priority over wen_i, ren_i and op_valid_i in the same cycle (all dropped); clr_i SHALL be ignored in other states.
REQ-016 op_ready_o SHALL equal (state==IDLE) && !clr_i && !wen_i; the plain write has priority over an RMW request.
REQ-017 An RMW SHALL be accepted on op_valid_i && op_ready_o at edge T; address and delta are captured; the FSM is in RMW_RD after T and RMW_WR after T+1.
REQ-018 At edge T+2 the FSM SHALL write the result to the cell, drive op_result_o to it, pulse op_done_o for one cycle and return to IDLE; the next op can be accepted at T+2.
REQ-019 Result, SAT_MODE=0: (cell + delta) mod 2^CELL_W.
REQ-020 Result, SAT_MODE=1: the cell is unsigned and delta is signed; clamp the sum to 0 or 2^CELL_W-1 (e.g. 8-bit 250+10 -> 255, 3-8 -> 0).
REQ-021 wen_i SHALL write only in IDLE with clr_i low; wen_i in RMW_RD or RMW_WR SHALL be dropped.
REQ-022 ren_i SHALL be honoured in IDLE, RMW_RD and RMW_WR.
REQ-023 For an honoured ren_i at edge N, rdata_o SHALL update at N and rvalid_o SHALL be high for the cycle after N; without a read, rdata_o holds and rvalid_o is low.
REQ-024 Reads SHALL be write-first: a read of an address being written at the same edge (plain or RMW write) returns the new value.
REQ-025 op_result_o SHALL hold its value between completions.

Reset
REQ-026 rst_i high at an edge SHALL abort any state and enter CLEAR at address 0, mid-clear or mid-RMW, with no partial RMW write.
REQ-027 While in reset and after it: rdata_o=0, rvalid_o=0, op_result_o=0, op_done_o=0, op_ready_o=0, busy_o=1.
REQ-028 After reset, all cells SHALL read 0 once busy_o falls, DEPTH cycles after rst_i deasserts; no memory initial block is relied on.

Structure
REQ-029 Package tinybf_pkg SHALL hold the FSM state typedef and the SAT_MODE encodings (SAT_WRAP=0, SAT_CLAMP=1).
REQ-030 The arithmetic SHALL be a combinational sub-module tape_cell_alu (CELL_W, SAT_MODE; cell, delta -> result).
REQ-031 Storage SHALL be one register array with one write per cycle; the clear counter SHALL be AW bits.

Verification
REQ-032 Reset then idle: busy_o high 16 cycles (DEPTH=16) then low; reads of all 16 addresses give rdata_o=0 with rvalid_o.
REQ-033 Write 0x05 to addr 3, then RMW addr 3 delta 0xFF (-1): op_done_o two cycles after accept, op_result_o=0x04, and a later read of addr 3 gives 0x04.
REQ-034 SAT_MODE=0 vs 1: cell 0xFA plus delta 0x0A gives 0x04 (wrap) or 0xFF (clamp); cell 0x03 plus delta 0xF8 gives 0xFB (wrap) or 0x00 (clamp).
REQ-035 Simultaneous events: wen_i and op_valid_i in the same cycle -> op_ready_o=0 and the write lands; ren_i on addr 3 during RMW_WR of addr 3 returns the new value.
REQ-036 clr_i in IDLE together with wen_i addr 2 = 0x7 -> busy_o for DEPTH cycles and addr 2 reads 0.
REQ-037 rst_i asserted one cycle after RMW accept -> no op_done_o and the targeted cell reads 0 after the clear.

Source files
------------

// File: rtl/tinybf_pkg.sv
// Shared types for the tape read-modify-write memory: FSM states and
// arithmetic mode encodings.
package tinybf_pkg;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_RMW_RD = 2'd2,
    S_RMW_WR = 2'd3
  } state_e;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

endpackage

// File: rtl/tape_cell_alu.sv
// Combinational cell update: unsigned cell plus two's-complement delta,
// either wrapping or clamped to the unsigned cell range.
module tape_cell_alu
  import tinybf_pkg::*;
#(
  parameter int CELL_W   = 8,
  parameter int SAT_MODE = SAT_WRAP
) (
  input  logic [CELL_W-1:0] cell_i,
  input  logic [CELL_W-1:0] delta_i,
  output logic [CELL_W-1:0] result_o
);

  // Two guard bits: the top one flags a negative sum, the next an overflow.
  logic [CELL_W+1:0] sum;

  assign sum = {2'b00, cell_i} + {{2{delta_i[CELL_W-1]}}, delta_i};

  generate
    if (SAT_MODE == SAT_CLAMP) begin : g_clamp
      always_comb begin
        if (sum[CELL_W+1]) begin
          result_o = '0;
        end else if (sum[CELL_W]) begin
          result_o = '1;
        end else begin
          result_o = sum[CELL_W-1:0];
        end
      end
    end else begin : g_wrap
      assign result_o = sum[CELL_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/tape_rmw_memory.sv
// Cell tape with a read port, a plain write port and a three-cycle
// read-modify-write engine; reset and clr_i sweep zeros through every cell.
module tape_rmw_memory
  import tinybf_pkg::*;
#(
  parameter int CELL_W   = 8,
  parameter int DEPTH    = 16,
  parameter int SAT_MODE = SAT_WRAP,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic              ren_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [CELL_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              wen_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [CELL_W-1:0] wdata_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [AW-1:0]     op_addr_i,
  input  logic [CELL_W-1:0] op_delta_i,
  output logic              op_done_o,
  output logic [CELL_W-1:0] op_result_o
);

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     clr_addr_q;
  logic [AW-1:0]     op_addr_q;
  logic [CELL_W-1:0] delta_q;
  logic [CELL_W-1:0] cell_q;
  logic [CELL_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [CELL_W-1:0] result_q;
  logic              done_q;

  logic [CELL_W-1:0] mem_q [DEPTH];

  logic              in_idle;
  logic              op_accept;
  logic              rd_en;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] rdata_d;
  logic [CELL_W-1:0] alu_result;

  tape_cell_alu #(
    .CELL_W  (CELL_W),
    .SAT_MODE(SAT_MODE)
  ) u_alu (
    .cell_i  (cell_q),
    .delta_i (delta_q),
    .result_o(alu_result)
  );

  assign in_idle    = (state_q == S_IDLE);
  assign busy_o     = (state_q == S_CLEAR);
  assign op_ready_o = in_idle && !clr_i && !wen_i;
  assign op_accept  = op_valid_i && op_ready_o;
  assign rd_en      = ren_i && ((in_idle && !clr_i) ||
                                (state_q == S_RMW_RD) || (state_q == S_RMW_WR));

  // Single write port shared by the clear sweep, plain writes and RMW commits.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
      end
      S_IDLE: begin
        mem_we    = wen_i && !clr_i;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
      end
      S_RMW_WR: begin
        mem_we    = 1'b1;
        mem_waddr = op_addr_q;
        mem_wdata = alu_result;
      end
      default: ;
    endcase
    if (rst_i) begin
      mem_we = 1'b0;
    end
  end

  assign rdata_d = (mem_we && (mem_waddr == raddr_i)) ? mem_wdata : mem_q[raddr_i];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      op_addr_q  <= '0;
      delta_q    <= '0;
      cell_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == CLR_LAST) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clr_i) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
          end else if (op_accept) begin
            op_addr_q <= op_addr_i;
            delta_q   <= op_delta_i;
            state_q   <= S_RMW_RD;
          end
        end
        S_RMW_RD: begin
          cell_q  <= mem_q[op_addr_q];
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: begin
          result_q <= alu_result;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign op_done_o   = done_q;
  assign op_result_o = result_q;

endmodule
